// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point constants, FSM state type and the sigmoid table
// used by the activation LUT fetch path.
package nn_fixed_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned FRAC_W     = 4;
    localparam int unsigned LUT_DEPTH  = 17;
    localparam int unsigned ADDR_W     = $clog2(LUT_DEPTH);
    localparam int unsigned IDX_OFFSET = 2 ** (DATA_W - FRAC_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_BASE,
        ST_RD_NEXT,
        ST_LATCH,
        ST_VALID
    } fsm_state_e;

    // Q4.4 round-to-nearest of 16*sigmoid(k), k = -8..8
    localparam logic [DATA_W-1:0] SIGMOID_LUT [LUT_DEPTH] = '{
        8'd0,  8'd0,  8'd0,  8'd0,  8'd0,  8'd1,  8'd2,  8'd4,  8'd8,
        8'd12, 8'd14, 8'd15, 8'd16, 8'd16, 8'd16, 8'd16, 8'd16
    };

endpackage

// File: rtl/activation_lut_rom.sv
// Synchronous-read ROM over the sigmoid table; data is valid the cycle
// after the address is presented.
module activation_lut_rom
    import nn_fixed_pkg::*;
(
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    // Addresses past the table read as zero so the unused code space is defined
    always_ff @(posedge clk) begin
        data <= (32'(addr) < LUT_DEPTH) ? SIGMOID_LUT[addr] : '0;
    end

endmodule

// File: rtl/activation_lut_fetch.sv
// Splits a signed fixed-point x into LUT index and fraction, fetches the two
// bracketing table entries and holds them for the downstream interpolator.
module activation_lut_fetch
    import nn_fixed_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] base,
    output logic [DATA_W-1:0] next__data,
    output logic [DATA_W-1:0] change,
    output logic [DATA_W-1:0] remaining
);

    fsm_state_e        state_q;
    logic [DATA_W-1:0] x_q;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] base_q;
    logic [DATA_W-1:0] next_q;
    logic [DATA_W-1:0] change_q;
    logic              in_ready_q;
    logic              out_valid_q;

    logic [ADDR_W-1:0] addr_base_c;
    logic [ADDR_W-1:0] addr_next_c;
    logic [ADDR_W-1:0] rom_addr_c;
    logic [DATA_W-1:0] rom_data;

    // Offsetting the signed index maps idx -8..7 onto addresses 0..15
    assign addr_base_c = ADDR_W'($signed(x_q) >>> FRAC_W) + ADDR_W'(IDX_OFFSET);
    assign addr_next_c = addr_base_c + ADDR_W'(1);

    always_comb begin
        rom_addr_c = '0;
        case (state_q)
            ST_RD_BASE: rom_addr_c = addr_base_c;
            ST_RD_NEXT: rom_addr_c = addr_next_c;
            default:    rom_addr_c = '0;
        endcase
    end

    activation_lut_rom u_rom (
        .clk  (clk),
        .addr (rom_addr_c),
        .data (rom_data)
    );

    // ROM data lags its address by one cycle, so each read lands a state later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            rem_q       <= '0;
            base_q      <= '0;
            next_q      <= '0;
            change_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        x_q        <= in_data;
                        rem_q      <= DATA_W'(in_data[FRAC_W-1:0]);
                        in_ready_q <= 1'b0;
                        state_q    <= ST_RD_BASE;
                    end
                end
                ST_RD_BASE: begin
                    state_q <= ST_RD_NEXT;
                end
                ST_RD_NEXT: begin
                    base_q  <= rom_data;
                    state_q <= ST_LATCH;
                end
                ST_LATCH: begin
                    next_q      <= rom_data;
                    change_q    <= rom_data - base_q;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_VALID;
                end
                ST_VALID: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign base       = base_q;
    assign next__data = next_q;
    assign change     = change_q;
    assign remaining  = rem_q;

endmodule

// File: tb/tb_activation_lut_fetch.sv
// Scoreboard bench for activation_lut_fetch: accepted inputs push expected
// operands computed from the sigmoid table; a monitor pops and compares.
module tb_activation_lut_fetch;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] base;
    logic [7:0] next__data;
    logic [7:0] change;
    logic [7:0] remaining;

    typedef struct {
        logic [7:0] x;
        logic [7:0] base;
        logic [7:0] nxt;
        logic [7:0] chg;
        logic [7:0] rem;
        int         acc;
    } exp_t;

    localparam int TBL [17] = '{0, 0, 0, 0, 0, 1, 2, 4, 8, 12, 14, 15, 16, 16, 16, 16, 16};

    exp_t exp_q [$];
    int   errors;
    int   checks;
    int   cyc;
    int   rdy_mode;   // 0: hold low, 1: hold high, 2: random

    activation_lut_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .base       (base),
        .next__data (next__data),
        .change     (change),
        .remaining  (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        if (rdy_mode == 0)      out_ready = 1'b0;
        else if (rdy_mode == 1) out_ready = 1'b1;
        else                    out_ready = ($urandom_range(0, 3) != 0);
    end

    function automatic exp_t model(input logic [7:0] x);
        exp_t e;
        int v, r, k;
        v = int'($signed(x));
        r = ((v % 16) + 16) % 16;
        k = (v - r) / 16;
        e.x    = x;
        e.base = 8'(TBL[k + 8]);
        e.nxt  = 8'(TBL[k + 9]);
        e.chg  = 8'(TBL[k + 9] - TBL[k + 8]);
        e.rem  = 8'(r);
        e.acc  = 0;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Present x until accepted; returns the cycle number of the accepting edge
    task automatic send(input logic [7:0] x, output int acc);
        exp_t e;
        bit   ok;
        ok  = 1'b0;
        acc = -1;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = x;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            acc   = cyc;
            e     = model(x);
            e.acc = acc;
            exp_q.push_back(e);
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: x=%02h not accepted within 100 cycles", x);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_base"}, int'(base), 0);
        chk({tag, "_next"}, int'(next__data), 0);
        chk({tag, "_change"}, int'(change), 0);
        chk({tag, "_remaining"}, int'(remaining), 0);
    endtask

    initial begin
        int   acc;
        int   rel;
        bit   seen;
        exp_t e;

        errors   = 0;
        checks   = 0;
        cyc      = 0;
        rdy_mode = 1;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        out_ready = 1'b1;

        // Monitor: checks latency on each rising out_valid and operands on each handshake
        fork
            begin
                bit   prev_v;
                exp_t m;
                prev_v = 1'b0;
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        prev_v = 1'b0;
                    end else begin
                        if (out_valid && !prev_v) begin
                            if (exp_q.size() == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL unexpected_out_valid: at cycle %0d with no pending input", cyc);
                            end else begin
                                chk("latency", cyc - exp_q[0].acc, 4);
                            end
                        end
                        if (out_valid && out_ready && exp_q.size() > 0) begin
                            m = exp_q.pop_front();
                            checks++;
                            if (base !== m.base || next__data !== m.nxt ||
                                change !== m.chg || remaining !== m.rem) begin
                                errors++;
                                $display("FAIL operands x=%02h: got b=%0d n=%0d c=%0d r=%0d expected b=%0d n=%0d c=%0d r=%0d",
                                         m.x, base, next__data, change, remaining,
                                         m.base, m.nxt, m.chg, m.rem);
                            end
                        end
                        prev_v = out_valid;
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready_during", int'(in_ready), 1);
        chk_zero_outputs("rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready_after", int'(in_ready), 1);

        // Directed points: zero, +1.5, -1.5, most negative, most positive
        send(8'h00, acc);
        send(8'h18, acc);
        send(8'hE8, acc);
        send(8'h80, acc);
        send(8'h7F, acc);

        // Backpressure: hold VALID for 10 cycles while a second x is offered
        repeat (8) @(posedge clk);
        rdy_mode = 0;
        send(8'h18, acc);
        e = model(8'h18);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        chk("stall_reached_valid", int'(seen), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 8'hE8;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (!out_valid || in_ready || base !== e.base || next__data !== e.nxt ||
                change !== e.chg || remaining !== e.rem) begin
                errors++;
                $display("FAIL stall_hold[%0d]: ov=%0d ir=%0d b=%0d n=%0d c=%0d r=%0d expected ov=1 ir=0 b=%0d n=%0d c=%0d r=%0d",
                         i, out_valid, in_ready, base, next__data, change, remaining,
                         e.base, e.nxt, e.chg, e.rem);
            end
        end
        @(posedge clk);
        #1;
        rdy_mode = 1;
        rel = cyc;
        send(8'hE8, acc);
        chk("accept_after_release", acc, rel + 1);

        // Reset while in RD_NEXT aborts the transaction
        repeat (8) @(posedge clk);
        send(8'h18, acc);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        #2;
        chk_zero_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("midrst_no_valid", int'(seen), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_base", int'(base), 0);
        send(8'h00, acc);

        // Random x with random downstream backpressure
        rdy_mode = 2;
        for (int n = 0; n < 40; n++) begin
            send(8'($urandom), acc);
        end

        for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results still pending", exp_q.size());
        end
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
